// File: rtl/ray_column_sequencer_if.sv
// Bus between the column sequencer, the horizontal/vertical wall-intersection finders
// and the downstream column renderer. The sequencer is the master side.
interface ray_column_sequencer_if;
    logic [11:0] ray_playerX;
    logic [11:0] ray_playerY;
    logic [11:0] alpha;
    logic        begin_calc;

    logic        h_end_calc;
    logic        h_wall_found;
    logic [11:0] h_wallX;
    logic [11:0] h_wallY;
    logic        v_end_calc;
    logic        v_wall_found;
    logic [11:0] v_wallX;
    logic [11:0] v_wallY;

    logic        col_valid;
    logic        col_ready;
    logic [8:0]  col_index;
    logic [11:0] col_alpha;
    logic        col_h_hit;
    logic [11:0] col_h_x;
    logic [11:0] col_h_y;
    logic        col_v_hit;
    logic [11:0] col_v_x;
    logic [11:0] col_v_y;

    modport master (
        output ray_playerX, ray_playerY, alpha, begin_calc,
        input  h_end_calc, h_wall_found, h_wallX, h_wallY,
        input  v_end_calc, v_wall_found, v_wallX, v_wallY,
        output col_valid, col_index, col_alpha,
        output col_h_hit, col_h_x, col_h_y, col_v_hit, col_v_x, col_v_y,
        input  col_ready
    );

    modport slave (
        input  ray_playerX, ray_playerY, alpha, begin_calc,
        output h_end_calc, h_wall_found, h_wallX, h_wallY,
        output v_end_calc, v_wall_found, v_wallX, v_wallY,
        input  col_valid, col_index, col_alpha,
        input  col_h_hit, col_h_x, col_h_y, col_v_hit, col_v_x, col_v_y,
        output col_ready
    );
endinterface

// File: rtl/ray_column_sequencer.sv
// Frame-level raycaster driver: walks the screen columns, launches both intersection
// finders per column, pairs their results and hands each column to the renderer.
module ray_column_sequencer #(
    parameter int NUM_COLS   = 320,
    parameter int ANGLE_FULL = 1920,
    parameter int FOV        = 320,
    parameter int ANGLE_STEP = 1,
    parameter int TIMEOUT    = 4095
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_frame,
    input  logic [11:0]            playerX,
    input  logic [11:0]            playerY,
    input  logic [11:0]            player_angle,
    output logic                   busy,
    output logic                   frame_done,
    ray_column_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    typedef struct packed {
        logic        hit;
        logic [11:0] x;
        logic [11:0] y;
    } hit_t;

    localparam logic [12:0] FULL13 = 13'(ANGLE_FULL);

    state_t      state_q,  state_d;
    logic [11:0] px_q,     px_d;
    logic [11:0] py_q,     py_d;
    logic [11:0] alpha_q,  alpha_d;
    logic [8:0]  col_q,    col_d;
    logic [11:0] timer_q,  timer_d;
    logic        h_done_q, h_done_d;
    logic        v_done_q, v_done_d;
    hit_t        h_res_q,  h_res_d;
    hit_t        v_res_q,  v_res_d;
    logic        begin_q,  begin_d;
    logic        valid_q,  valid_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    // Angles are kept in [0, ANGLE_FULL); the 13-bit sum absorbs the +ANGLE_FULL bias.
    function automatic logic [11:0] first_angle(input logic [11:0] pa);
        logic [12:0] a;
        a = {1'b0, pa} + FULL13 - 13'(FOV / 2);
        if (a >= FULL13) a = a - FULL13;
        if (a >= FULL13) a = a - FULL13;
        return a[11:0];
    endfunction

    function automatic logic [11:0] next_angle(input logic [11:0] cur);
        logic [12:0] a;
        a = {1'b0, cur} + 13'(ANGLE_STEP);
        if (a >= FULL13) a = a - FULL13;
        return a[11:0];
    endfunction

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        alpha_d  = alpha_q;
        col_d    = col_q;
        timer_d  = timer_q;
        h_done_d = h_done_q;
        v_done_d = v_done_q;
        h_res_d  = h_res_q;
        v_res_d  = v_res_q;
        begin_d  = 1'b0;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    px_d    = playerX;
                    py_d    = playerY;
                    col_d   = '0;
                    alpha_d = first_angle(player_angle);
                    begin_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                h_done_d = 1'b0;
                v_done_d = 1'b0;
                h_res_d  = '0;
                v_res_d  = '0;
                timer_d  = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (h_done_q && v_done_q) begin
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else begin
                    // First end_calc from each finder wins; repeats are dropped.
                    if (bus.h_end_calc && !h_done_q) begin
                        h_done_d = 1'b1;
                        h_res_d  = '{hit: bus.h_wall_found, x: bus.h_wallX, y: bus.h_wallY};
                    end
                    if (bus.v_end_calc && !v_done_q) begin
                        v_done_d = 1'b1;
                        v_res_d  = '{hit: bus.v_wall_found, x: bus.v_wallX, y: bus.v_wallY};
                    end
                    // A silent finder leaves its cleared result, i.e. a reported miss.
                    if (timer_q == 12'(TIMEOUT)) begin
                        valid_d = 1'b1;
                        state_d = EMIT;
                    end else begin
                        timer_d = timer_q + 12'd1;
                    end
                end
            end
            EMIT: begin
                if (bus.col_ready) begin
                    valid_d = 1'b0;
                    if (col_q < 9'(NUM_COLS - 1)) begin
                        col_d   = col_q + 9'd1;
                        alpha_d = next_angle(alpha_q);
                        begin_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: result capture registers are reset too, so every output reads 0 out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            px_q     <= '0;
            py_q     <= '0;
            alpha_q  <= '0;
            col_q    <= '0;
            timer_q  <= '0;
            h_done_q <= 1'b0;
            v_done_q <= 1'b0;
            h_res_q  <= '0;
            v_res_q  <= '0;
            begin_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            alpha_q  <= alpha_d;
            col_q    <= col_d;
            timer_q  <= timer_d;
            h_done_q <= h_done_d;
            v_done_q <= v_done_d;
            h_res_q  <= h_res_d;
            v_res_q  <= v_res_d;
            begin_q  <= begin_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.ray_playerX = px_q;
    assign bus.ray_playerY = py_q;
    assign bus.alpha       = alpha_q;
    assign bus.begin_calc  = begin_q;
    assign bus.col_valid   = valid_q;
    assign bus.col_index   = col_q;
    assign bus.col_alpha   = alpha_q;
    assign bus.col_h_hit   = h_res_q.hit;
    assign bus.col_h_x     = h_res_q.x;
    assign bus.col_h_y     = h_res_q.y;
    assign bus.col_v_hit   = v_res_q.hit;
    assign bus.col_v_x     = v_res_q.x;
    assign bus.col_v_y     = v_res_q.y;
    assign busy            = busy_q;
    assign frame_done      = done_q;
endmodule

// File: tb/tb_ray_column_sequencer.sv
// Bench for ray_column_sequencer: emulated finders and renderer on the falling edge,
// a per-column scoreboard built from the angle/handshake rules, plus an alpha table.
module tb_ray_column_sequencer;
    localparam int NUM_COLS   = 320;
    localparam int ANGLE_FULL = 1920;
    localparam int FOV        = 320;
    localparam int TIMEOUT    = 4095;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_frame = 1'b0;
    logic [11:0] playerX = '0;
    logic [11:0] playerY = '0;
    logic [11:0] player_angle = '0;
    logic        busy;
    logic        frame_done;

    ray_column_sequencer_if bus();

    ray_column_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start_frame  (start_frame),
        .playerX      (playerX),
        .playerY      (playerY),
        .player_angle (player_angle),
        .busy         (busy),
        .frame_done   (frame_done),
        .bus          (bus)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int          col;
        logic [11:0] alpha;
        logic [24:0] h;        // {hit, x, y}
        logic [24:0] v;
        int          t_begin;
        bit          forced;
        int          lat_exp;
    } col_exp_t;

    typedef struct {
        int angle;
        int col;
        int exp_alpha;
    } alpha_vec_t;

    int nvec = 0;
    int nmis = 0;

    col_exp_t    exp_q[$];
    int          obs_alpha[NUM_COLS];
    int          h_dly_cfg = 3, v_dly_cfg = 3;
    bit          rand_dly = 0, dup_h = 0;
    int          v_never_col = -1, hold_col = -1;
    int          ready_mode = 0;
    int          frame_angle = 0;
    logic [11:0] frame_px, frame_py;
    int          issued = 0, hs_cnt = 0, fd_cnt = 0, cyc_no = 0;
    bit          run_en = 0;
    int          since = -1, cur_hd = 0, cur_vd = 0, hold_n = 0;
    bit          valid_seen = 1;
    logic [24:0] cur_h, cur_v, dup_val;
    logic [70:0] snap;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        nvec++;
        if (v < lo || v > hi) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    // Reference angle of column c: start half a field of view left of the view angle.
    function automatic int model_alpha(input int ang, input int c);
        return (ang + ANGLE_FULL - FOV / 2 + c) % ANGLE_FULL;
    endfunction

    function automatic logic [70:0] col_pack();
        return {bus.col_index, bus.col_alpha, bus.col_h_hit, bus.col_h_x, bus.col_h_y,
                bus.col_v_hit, bus.col_v_x, bus.col_v_y};
    endfunction

    function automatic logic [127:0] outs_pack();
        return 128'({busy, frame_done, bus.begin_calc, bus.col_valid,
                     bus.ray_playerX, bus.ray_playerY, bus.alpha, col_pack()});
    endfunction

    // One falling-edge step of the finder pair and the renderer.
    task automatic step();
        col_exp_t e;
        logic     r;
        int       lat;
        bus.h_end_calc   = 1'b0;
        bus.v_end_calc   = 1'b0;
        bus.h_wall_found = 1'($urandom);
        bus.h_wallX      = 12'($urandom);
        bus.h_wallY      = 12'($urandom);
        bus.v_wall_found = 1'($urandom);
        bus.v_wallX      = 12'($urandom);
        bus.v_wallY      = 12'($urandom);

        if (bus.begin_calc) begin
            check("begin_while_pending", exp_q.size(), 0);
            check("alpha_at_begin", bus.alpha, model_alpha(frame_angle, issued));
            check("ray_player", {bus.ray_playerX, bus.ray_playerY}, {frame_px, frame_py});
            cur_hd  = rand_dly ? $urandom_range(1, 8) : h_dly_cfg;
            cur_vd  = rand_dly ? $urandom_range(1, 8) : v_dly_cfg;
            if (issued == v_never_col) cur_vd = 0;
            cur_h   = {1'($urandom), 12'($urandom), 12'($urandom)};
            cur_v   = {1'($urandom), 12'($urandom), 12'($urandom)};
            dup_val = ~cur_h;
            e.col     = issued;
            e.alpha   = 12'(model_alpha(frame_angle, issued));
            e.h       = (cur_hd == 0) ? 25'd0 : cur_h;
            e.v       = (cur_vd == 0) ? 25'd0 : cur_v;
            e.t_begin = cyc_no;
            e.forced  = (cur_hd == 0) || (cur_vd == 0);
            e.lat_exp = ((cur_hd > cur_vd) ? cur_hd : cur_vd) + 2;
            exp_q.push_back(e);
            issued++;
            since      = 0;
            valid_seen = 0;
        end else if (since >= 0) begin
            since++;
        end

        if (since > 0 && since == cur_hd)
            {bus.h_end_calc, bus.h_wall_found, bus.h_wallX, bus.h_wallY} = {1'b1, cur_h};
        if (since > 0 && dup_h && since == cur_hd + 2)
            {bus.h_end_calc, bus.h_wall_found, bus.h_wallX, bus.h_wallY} = {1'b1, dup_val};
        if (since > 0 && since == cur_vd) begin
            {bus.v_end_calc, bus.v_wall_found, bus.v_wallX, bus.v_wallY} = {1'b1, cur_v};
            if (exp_q.size() > 0) check("alpha_stable_wait", bus.alpha, exp_q[0].alpha);
        end

        if (bus.col_valid && !valid_seen && exp_q.size() > 0) begin
            valid_seen = 1;
            lat = cyc_no - exp_q[0].t_begin;
            if (exp_q[0].forced) check_range("timeout_latency", lat, TIMEOUT, TIMEOUT + 4);
            else                 check("emit_latency", lat, exp_q[0].lat_exp);
        end

        r = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.col_valid && int'(bus.col_index) == hold_col && hold_n < 10) begin
            r = 1'b0;
            if (hold_n == 0) snap = col_pack();
            else             check("hold_col_stable", col_pack(), snap);
            check("hold_no_begin", bus.begin_calc, 0);
            if (hold_n == 4) begin
                bus.h_end_calc = 1'b1;
                bus.h_wallX    = ~bus.col_h_x;
            end
            hold_n++;
        end
        bus.col_ready = r;

        if (bus.col_valid && r) begin
            if (exp_q.size() == 0) begin
                check("col_without_begin", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("col_index", bus.col_index, e.col);
                check("col_alpha", bus.col_alpha, e.alpha);
                check("col_h", {bus.col_h_hit, bus.col_h_x, bus.col_h_y}, e.h);
                check("col_v", {bus.col_v_hit, bus.col_v_x, bus.col_v_y}, e.v);
                obs_alpha[e.col] = int'(bus.col_alpha);
            end
            hs_cnt++;
        end

        if (frame_done) begin
            fd_cnt++;
            check("frame_done_after_last", hs_cnt, NUM_COLS);
        end
    endtask

    initial forever begin
        @(negedge clock);
        cyc_no++;
        if (run_en) step();
    end

    task automatic launch(input int ang, input int px, input int py);
        frame_angle = ang;
        frame_px    = 12'(px);
        frame_py    = 12'(py);
        issued = 0; hs_cnt = 0; fd_cnt = 0; hold_n = 0; since = -1; valid_seen = 1;
        exp_q.delete();
        foreach (obs_alpha[i]) obs_alpha[i] = -1;
        @(negedge clock);
        start_frame  = 1'b1;
        playerX      = 12'(px);
        playerY      = 12'(py);
        player_angle = 12'(ang);
        @(negedge clock);
        start_frame = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_frame(input int ang, input int px, input int py, input bit poke);
        int budget = 0;
        bit poked  = 0;
        launch(ang, px, py);
        while (fd_cnt == 0 && budget < 20000) begin
            @(negedge clock);
            budget++;
            start_frame = 1'b0;
            if (poke && !poked && hs_cnt >= 50) begin
                start_frame  = 1'b1;
                playerX      = ~playerX;
                playerY      = ~playerY;
                player_angle = 12'((ang + 500) % ANGLE_FULL);
                poked        = 1;
            end
        end
        check("frame_done_seen", fd_cnt > 0, 1);
        repeat (3) @(negedge clock);
        check("frame_done_once", fd_cnt, 1);
        check("cols_per_frame", hs_cnt, NUM_COLS);
        check("idle_after_frame", {busy, bus.col_valid}, 0);
    endtask

    alpha_vec_t vecs[12];

    initial begin
        int last_angle;
        int budget;
        vecs = '{'{0, 0, 1760}, '{0, 159, 1919}, '{0, 160, 0}, '{0, 319, 159},
                 '{100, 0, 1860}, '{100, 59, 1919}, '{100, 60, 0},
                 '{1000, 0, 840}, '{1000, 319, 1159},
                 '{1919, 0, 1759}, '{1919, 160, 1919}, '{1919, 161, 0}};
        bus.h_end_calc = 1'b0; bus.h_wall_found = 1'b0; bus.h_wallX = '0; bus.h_wallY = '0;
        bus.v_end_calc = 1'b0; bus.v_wall_found = 1'b0; bus.v_wallX = '0; bus.v_wallY = '0;
        bus.col_ready  = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_outputs", outs_pack(), 0);
        reset = 1'b0;

        // Stray end_calc while idle must not start or disturb anything.
        @(negedge clock);
        bus.h_end_calc = 1'b1; bus.h_wall_found = 1'b1; bus.h_wallX = 12'hABC;
        bus.v_end_calc = 1'b1; bus.v_wall_found = 1'b1; bus.v_wallY = 12'h123;
        @(negedge clock);
        bus.h_end_calc = 1'b0; bus.v_end_calc = 1'b0;
        @(negedge clock);
        check("idle_after_stray", {busy, bus.col_valid, bus.begin_calc, col_pack()}, 0);
        run_en = 1;

        // Angle sweep: echo after 3 cycles, renderer always ready.
        last_angle = -1;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].angle != last_angle) begin
                run_frame(vecs[i].angle, 100 + i, 200 + i, 0);
                last_angle = vecs[i].angle;
            end
            check("table_alpha", obs_alpha[vecs[i].col], vecs[i].exp_alpha);
        end

        // Skewed finders with a repeated h pulse, and a 10-cycle renderer stall at col 200.
        h_dly_cfg = 2; v_dly_cfg = 7; dup_h = 1; hold_col = 200;
        run_frame(300, 1234, 567, 0);
        dup_h = 0; hold_col = -1; h_dly_cfg = 5; v_dly_cfg = 5;
        run_frame(1500, 50, 60, 0);

        // Vertical finder silent on column 10.
        h_dly_cfg = 3; v_dly_cfg = 3; v_never_col = 10;
        run_frame(800, 7, 9, 0);
        v_never_col = -1;

        // Reset in the middle of column 100's wait.
        h_dly_cfg = 7; v_dly_cfg = 7;
        launch(600, 11, 22);
        budget = 0;
        while (issued < 101 && budget < 5000) begin
            @(negedge clock);
            budget++;
        end
        check("reached_col100", issued, 101);
        repeat (3) @(negedge clock);
        run_en = 0;
        bus.h_end_calc = 1'b0; bus.v_end_calc = 1'b0; bus.col_ready = 1'b0;
        #2 reset = 1'b1;
        #1 check("reset_mid_frame", outs_pack(), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check("no_done_after_abort", {busy, frame_done}, 0);
        end
        run_en = 1;
        run_frame(600, 11, 22, 0);

        // Random finder latencies and renderer stalls; start_frame and playerX poked mid-frame.
        rand_dly = 1; ready_mode = 1;
        run_frame(1700, 3000, 4000, 1);
        run_frame($urandom_range(0, ANGLE_FULL - 1), $urandom_range(0, 4095),
                  $urandom_range(0, 4095), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
